// File: rtl/data_memory_responder_if.sv
// Cache-line memory bus between the dcache controller (master) and the data memory (slave).
interface data_memory_responder_if #(
  parameter int unsigned LINE_BITS = 256
);
  logic                 enable_i;
  logic                 write_i;
  logic [31:0]          addr_i;
  logic [LINE_BITS-1:0] data_i;
  logic                 ack_o;
  logic [LINE_BITS-1:0] data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/data_memory_responder.sv
// Off-chip data memory model: one line read/write per request, single-cycle ack after LATENCY.
// Optional protocol checker enabled by defining DMEM_PROTO_CHECK_EN.
module data_memory_responder #(
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned LATENCY   = 10
) (
  input logic                     clk_i,
  input logic                     rst_i,
  data_memory_responder_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 wr_q, wr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic                 ack_q, ack_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;

  // Not reset: contents survive rst_i.
  logic [LINE_BITS-1:0] mem [DEPTH];

  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:IdxW+5], bus.addr_i[4:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable_i) begin
          idx_d   = bus.addr_i[IdxW+4:5];
          wr_d    = bus.write_i;
          wdata_d = bus.data_i;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!bus.enable_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StAck;
          ack_d   = 1'b1;
          rdata_d = wr_q ? '0 : mem[idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Commit at the end of the ack cycle; a reset during ack drops state_q first and discards it.
  always_ff @(posedge clk_i) begin
    if (state_q == StAck && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdata_q;

`ifdef DMEM_PROTO_CHECK_EN
  logic        proto_err_q;
  logic [31:0] addr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      proto_err_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      if (state_q == StIdle && bus.enable_i) begin
        addr_q <= bus.addr_i;
      end
      if (state_q == StBusy) begin
        if (!bus.enable_i) begin
          proto_err_q <= 1'b1;
          $error("data_memory_responder: enable dropped before ack");
        end else if (bus.addr_i != addr_q || bus.write_i != wr_q ||
                     (wr_q && bus.data_i != wdata_q)) begin
          proto_err_q <= 1'b1;
          $error("data_memory_responder: request fields changed while busy");
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: scoreboard of expected ack data, reference line model.
module tb_data_memory_responder;

  localparam int unsigned LATENCY = 10;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [255:0] model [512];
  logic [255:0] exp_q [$];

  data_memory_responder_if #(.LINE_BITS(256)) bus ();

  data_memory_responder #(
    .LINE_BITS (256),
    .DEPTH     (512),
    .LATENCY   (LATENCY)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Drive a request and wait (bounded) for ack; enable stays high on return.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [255:0] d,
                       input int chg_cycle, input logic [31:0] alt_addr,
                       output int cyc, output logic got);
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = addr;
    bus.data_i   = d;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == chg_cycle) bus.addr_i = alt_addr;
      if (bus.ack_o === 1'b1) got = 1'b1;
    end
  endtask

  task automatic transact(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [255:0] d, input int chg_cycle, input logic [31:0] alt_addr);
    int           cyc;
    logic         got;
    logic [255:0] exp;
    exp_q.push_back(wr ? 256'd0 : model[addr[13:5]]);
    issue(wr, addr, d, chg_cycle, alt_addr, cyc, got);
    check({tag, "_latency"}, 256'(cyc), 256'(LATENCY + 1));
    exp = exp_q.pop_front();
    if (got) begin
      check({tag, "_data"}, bus.data_o, exp);
      if (wr) model[addr[13:5]] = d;
    end
    bus.enable_i = 1'b0;
    @(negedge clk);
    check({tag, "_ack_drop"}, 256'(bus.ack_o), 256'd0);
    check({tag, "_data_drop"}, bus.data_o, 256'd0);
  endtask

  initial begin
    int           cyc;
    logic         got;
    logic         seen;
    logic [255:0] d_a5;
    logic [255:0] d_rnd;

    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 512; i++) model[i] = '0;
    d_a5  = {32{8'hA5}};
    d_rnd = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};

    rst          = 1'b1;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    repeat (2) @(negedge clk);
    check("reset_ack", 256'(bus.ack_o), 256'd0);
    check("reset_data", bus.data_o, 256'd0);
    rst = 1'b0;

    // 1: read of untouched line
    transact("rd_0x40", 1'b0, 32'h0000_0040, '0, -1, '0);
    // 2: write then read back
    transact("wr_0x100", 1'b1, 32'h0000_0100, d_a5, -1, '0);
    transact("rd_0x100", 1'b0, 32'h0000_0100, '0, -1, '0);
    // 3: address wrap and ignored low bits
    transact("rd_0x4100", 1'b0, 32'h0000_4100, '0, -1, '0);
    transact("rd_0x411f", 1'b0, 32'hFFFF_411F, '0, -1, '0);
    // last line via wrapped alias
    transact("wr_0x3fe0", 1'b1, 32'h0000_3FE0, d_rnd, -1, '0);
    transact("rd_0xffe0", 1'b0, 32'h0000_FFE0, '0, -1, '0);

    // 4: aborted write leaves old data
    transact("wr_0x200", 1'b1, 32'h0000_0200, {32{8'h11}}, -1, '0);
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_0200;
    bus.data_i   = {32{8'h22}};
    repeat (4) @(negedge clk);
    bus.enable_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ack_o !== 1'b0) seen = 1'b1;
    end
    check("abort_no_ack", 256'(seen), 256'd0);
    transact("rd_0x200", 1'b0, 32'h0000_0200, '0, -1, '0);

    // 5: reset in the middle of a read
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b0;
    bus.addr_i   = 32'h0000_0100;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy_ack", 256'(bus.ack_o), 256'd0);
    check("rst_busy_data", bus.data_o, 256'd0);
    bus.enable_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    transact("rd_after_rst", 1'b0, 32'h0000_0100, '0, -1, '0);

    // reset during a read ack clears the registered outputs at once
    issue(1'b0, 32'h0000_0100, '0, -1, '0, cyc, got);
    check("rst_ack_seen", 256'(got), 256'd1);
    check("rst_ack_data_before", bus.data_o, d_a5);
    rst = 1'b1;
    #1;
    check("rst_ack_ack", 256'(bus.ack_o), 256'd0);
    check("rst_ack_data", bus.data_o, 256'd0);
    bus.enable_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // reset during a write ack discards the write
    issue(1'b1, 32'h0000_0100, {32{8'h33}}, -1, '0, cyc, got);
    check("rst_wr_ack_seen", 256'(got), 256'd1);
    rst = 1'b1;
    bus.enable_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    transact("rd_wr_discarded", 1'b0, 32'h0000_0100, '0, -1, '0);

    // 6: address changes while busy; the latched address is served
    transact("rd_addr_chg", 1'b0, 32'h0000_0100, '0, 3, 32'h0000_0200);
`ifdef DMEM_PROTO_CHECK_EN
    check("proto_err", 256'(dut.proto_err_q), 256'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
